// File: rtl/sti_pkg.sv
// sti_pkg: shared STI link encodings used by the receiver and transmitter side
// Holds the frame state encoding, frame length codes and the table of
// last-bit indices (N-1) for each length code.
package sti_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RECV, DONE} sti_state_e;
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;
  localparam logic [4:0] LAST_IDX [4] = '{5'd7, 5'd15, 5'd23, 5'd31};
endpackage

// File: rtl/sti_rx_extract.sv
// sti_rx_extract: recovers the 16-bit word from an MSB-aligned STI frame buffer
// Ports: frame (32-bit buffer, frame bits in [31:32-N]), length/fill/low
// (frame format), word (recovered 16-bit parallel word).
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] frame,
  input  logic [1:0]  length,
  input  logic        fill,
  input  logic        low,
  output logic [15:0] word
);
  always_comb
    word = length == LEN_8 ? (low ? {frame[31:24], 8'h00} : {8'h00, frame[31:24]})
         : (length == LEN_16 || fill) ? frame[31:16]
         : length == LEN_24 ? frame[23:8] : frame[15:0];
endmodule

// File: rtl/sti_rx.sv
// sti_rx: STI serial-to-parallel receiver (8/16/24/32-bit frames, MSB/LSB-first)
// Ports: clk, reset (async, active-high); cfg_load/cfg_length/cfg_fill/cfg_msb/
// cfg_low frame format; si_data/si_valid serial input; po_data/po_frame/po_valid
// recovered word and raw frame; po_busy (armed or receiving); err_short abort pulse.
// Macro STI_RX_ERR_EN: a si_valid gap mid-frame aborts the frame instead of stalling.
module sti_rx
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        si_data,
  input  logic        si_valid,
  output logic [15:0] po_data,
  output logic [31:0] po_frame,
  output logic        po_valid,
  output logic        po_busy,
  output logic        err_short
);
  sti_state_e state, state_nx;
  logic [5:0]  count;
  logic [1:0]  len_q;
  logic        fill_q, msb_q, low_q;
  logic [31:0] frame_q;
  logic [15:0] word;
  logic [4:0]  last, pos;
  logic        arm, take, abort;
  assign last = LAST_IDX[len_q];
  // LSB-first frames are still packed at the top of the buffer, so bit k lands at 31-(N-1)+k
  assign pos = msb_q ? 5'd31 - count[4:0] : 5'd31 - last + count[4:0];
  assign arm = cfg_load && state != RECV;
  assign take = si_valid && (state == RECV || (state == ARMED && !cfg_load));
`ifdef STI_RX_ERR_EN
  assign abort = state == RECV && !si_valid;
`else
  assign abort = 1'b0;
`endif
  assign po_busy = state == ARMED || state == RECV;
  sti_rx_extract u_extract (
    .frame  (frame_q),
    .length (len_q),
    .fill   (fill_q),
    .low    (low_q),
    .word   (word)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cfg_load ? ARMED : IDLE;
      ARMED:   state_nx = (!cfg_load && si_valid) ? RECV : ARMED;
      RECV:    state_nx = abort ? IDLE : (si_valid && count == {1'b0, last}) ? DONE : RECV;
      default: state_nx = cfg_load ? ARMED : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count     <= '0;
      len_q     <= '0;
      fill_q    <= 1'b0;
      msb_q     <= 1'b0;
      low_q     <= 1'b0;
      frame_q   <= '0;
      po_data   <= '0;
      po_frame  <= '0;
      po_valid  <= 1'b0;
      err_short <= 1'b0;
    end else begin
      po_valid  <= state == DONE;
      err_short <= abort;
      if (state == DONE) begin
        po_data  <= word;
        po_frame <= frame_q;
      end
      if (arm) begin
        len_q   <= cfg_length;
        fill_q  <= cfg_fill;
        msb_q   <= cfg_msb;
        low_q   <= cfg_low;
        frame_q <= '0;
        count   <= '0;
      end else if (take) begin
        frame_q[pos] <= si_data;
        count        <= count + 6'd1;
      end
    end
endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: self-checking bench for sti_rx with a value-level frame model
module tb_sti_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_length = '0;
  logic        cfg_fill = 1'b0, cfg_msb = 1'b0, cfg_low = 1'b0;
  logic        si_data = 1'b0, si_valid = 1'b0;
  logic [15:0] po_data;
  logic [31:0] po_frame;
  logic        po_valid, po_busy, err_short;
  int errors = 0, checks = 0;
  int valid_seen = 0, err_seen = 0;
  logic [15:0] last_word = '0;

  sti_rx dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
    .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
    .si_data(si_data), .si_valid(si_valid), .po_data(po_data),
    .po_frame(po_frame), .po_valid(po_valid), .po_busy(po_busy), .err_short(err_short)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (po_valid) valid_seen++;
    if (err_short) err_seen++;
  end

  function automatic logic [31:0] mask(int n, logic [31:0] v);
    return n == 32 ? v : v & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] model_frame(int n, logic [31:0] v);
    return mask(n, v) << (32 - n);
  endfunction

  function automatic logic [15:0] model_word(int n, logic fill, logic low, logic [31:0] v);
    case (n)
      8:       return low ? {v[7:0], 8'h00} : {8'h00, v[7:0]};
      16:      return v[15:0];
      24:      return fill ? v[23:8] : v[15:0];
      default: return fill ? v[31:16] : v[15:0];
    endcase
  endfunction

  task automatic load(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    @(negedge clk);
    cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic send_bits(input int n, input logic msb, input logic [31:0] v, input int gap_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == gap_at) begin
        si_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      si_data = msb ? v[n-1-k] : v[k];
      si_valid = 1'b1;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      si_valid = 1'b0;
      if (po_valid) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] len, input logic fill, input logic msb,
                           input logic low, input logic [31:0] v, output int lat);
    load(len, fill, msb, low);
    send_bits(8 * (len + 1), msb, v, -1);
    wait_valid(lat);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({po_data, po_frame, po_valid, po_busy, err_short} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h frame=%h valid=%b busy=%b err=%b, want all 0",
               po_data, po_frame, po_valid, po_busy, err_short);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed;
    int lat;
    run_frame(2'b01, 1'b0, 1'b1, 1'b0, 32'hA5C3, lat);
    checks += 4;
    if (lat !== 1) begin errors++; $display("FAIL d16_latency: got %0d want 1", lat); end
    if (po_data !== 16'hA5C3) begin errors++; $display("FAIL d16_data: got %h want a5c3", po_data); end
    if (po_frame !== 32'hA5C30000) begin errors++; $display("FAIL d16_frame: got %h want a5c30000", po_frame); end
    @(posedge clk); #1;
    if (po_valid !== 1'b0) begin errors++; $display("FAIL d16_pulse: po_valid got %b want 0", po_valid); end
    run_frame(2'b00, 1'b0, 1'b0, 1'b1, 32'h3C, lat);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL d8_latency: got %0d want 1", lat); end
    if (po_data !== 16'h3C00) begin errors++; $display("FAIL d8_data: got %h want 3c00", po_data); end
    if (po_frame !== 32'h3C000000) begin errors++; $display("FAIL d8_frame: got %h want 3c000000", po_frame); end
    run_frame(2'b10, 1'b0, 1'b1, 1'b0, 32'h00BEEF, lat);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL d24_latency: got %0d want 1", lat); end
    if (po_data !== 16'hBEEF) begin errors++; $display("FAIL d24_data: got %h want beef", po_data); end
    if (po_frame !== 32'h00BEEF00) begin errors++; $display("FAIL d24_frame: got %h want 00beef00", po_frame); end
    last_word = 16'hBEEF;
  endtask

  task automatic test_back_to_back;
    int lat;
    load(2'b11, 1'b0, 1'b0, 1'b0);
    send_bits(32, 1'b0, 32'h00001234, -1);
    @(posedge clk); #1;
    si_valid = 1'b0;
    cfg_length = 2'b00; cfg_fill = 1'b0; cfg_msb = 1'b1; cfg_low = 1'b0; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    checks += 4;
    if (po_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", po_valid); end
    if (po_data !== 16'h1234) begin errors++; $display("FAIL b2b_data1: got %h want 1234", po_data); end
    if (po_frame !== 32'h00001234) begin errors++; $display("FAIL b2b_frame1: got %h want 00001234", po_frame); end
    if (po_busy !== 1'b1) begin errors++; $display("FAIL b2b_armed: po_busy got %b want 1", po_busy); end
    send_bits(8, 1'b1, 32'hA7, -1);
    wait_valid(lat);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL b2b_latency2: got %0d want 1", lat); end
    if (po_data !== 16'h00A7) begin errors++; $display("FAIL b2b_data2: got %h want 00a7", po_data); end
    if (po_frame !== 32'hA7000000) begin errors++; $display("FAIL b2b_frame2: got %h want a7000000", po_frame); end
    last_word = 16'h00A7;
  endtask

  task automatic test_gap;
    logic [31:0] v;
    v = {16'h0, 16'($urandom)};
    load(2'b01, 1'b0, 1'b1, 1'b0);
    valid_seen = 0; err_seen = 0;
    send_bits(16, 1'b1, v, 6);
    @(negedge clk);
    si_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks += 3;
`ifdef STI_RX_ERR_EN
    if (err_seen !== 1) begin errors++; $display("FAIL gap_err: err_short pulses got %0d want 1", err_seen); end
    if (valid_seen !== 0) begin errors++; $display("FAIL gap_novalid: po_valid pulses got %0d want 0", valid_seen); end
    if (po_data !== last_word) begin errors++; $display("FAIL gap_hold: po_data got %h want %h", po_data, last_word); end
`else
    if (err_seen !== 0) begin errors++; $display("FAIL gap_err: err_short pulses got %0d want 0", err_seen); end
    if (valid_seen !== 1) begin errors++; $display("FAIL gap_valid: po_valid pulses got %0d want 1", valid_seen); end
    if (po_data !== v[15:0]) begin errors++; $display("FAIL gap_data: po_data got %h want %h", po_data, v[15:0]); end
    last_word = v[15:0];
`endif
  endtask

  task automatic test_random;
    int lat, n;
    logic [1:0] len;
    logic fill, msb, low;
    logic [31:0] v;
    for (int i = 0; i < 10; i++) begin
      len = 2'($urandom_range(0, 3));
      fill = 1'($urandom); msb = 1'($urandom); low = 1'($urandom);
      n = 8 * (len + 1);
      v = mask(n, $urandom);
      err_seen = 0;
      run_frame(len, fill, msb, low, v, lat);
      checks += 4;
      if (lat !== 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 1", i, lat); end
      if (po_data !== model_word(n, fill, low, v))
        begin errors++; $display("FAIL rnd%0d_data: got %h want %h", i, po_data, model_word(n, fill, low, v)); end
      if (po_frame !== model_frame(n, v))
        begin errors++; $display("FAIL rnd%0d_frame: got %h want %h", i, po_frame, model_frame(n, v)); end
      if (err_seen !== 0) begin errors++; $display("FAIL rnd%0d_err: err_short pulses got %0d want 0", i, err_seen); end
      last_word = model_word(n, fill, low, v);
    end
  endtask

  task automatic test_reset_mid_frame;
    int lat;
    logic [31:0] v;
    v = $urandom | 32'h1;
    load(2'b11, 1'b1, 1'b1, 1'b0);
    send_bits(10, 1'b1, v, -1);
    @(negedge clk);
    si_data = v[21]; si_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    valid_seen = 0; err_seen = 0;
    checks++;
    if ({po_data, po_frame, po_valid, po_busy, err_short} !== 51'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got data=%h frame=%h valid=%b busy=%b err=%b, want all 0",
               po_data, po_frame, po_valid, po_busy, err_short);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    si_valid = 1'b0;
    checks += 3;
    if (valid_seen !== 0) begin errors++; $display("FAIL midreset_novalid: got %0d want 0", valid_seen); end
    if (err_seen !== 0) begin errors++; $display("FAIL midreset_noerr: got %0d want 0", err_seen); end
    if (po_busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: po_busy got %b want 0", po_busy); end
    run_frame(2'b00, 1'b0, 1'($urandom), 1'b0, 32'hFF, lat);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL post_reset_latency: got %0d want 1", lat); end
    if (po_data !== 16'h00FF) begin errors++; $display("FAIL post_reset_data: got %h want 00ff", po_data); end
    if (po_frame !== 32'hFF000000) begin errors++; $display("FAIL post_reset_frame: got %h want ff000000", po_frame); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_gap;
    test_random;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
